// File: rtl/max_min_tracker.sv
// Frame-based max/min tracker: collects FRAME_LEN samples, reports max, min and
// the first index of the max, and emits a one-hot compare code per accepted sample.
module max_min_tracker #(
    parameter int DATA_W    = 8,
    parameter int FRAME_LEN = 4
) (
    input  logic              iClk,
    input  logic              iRst_n,
    input  logic              iValid,
    input  logic [DATA_W-1:0] iData,
    output logic              oReady,
    output logic [2:0]        oCmp,
    output logic              oValid,
    output logic [DATA_W-1:0] oMax,
    output logic [DATA_W-1:0] oMin,
    output logic [3:0]        oMaxIdx,
    input  logic              iAck,
    output logic [1:0]        oDbgState
);

    localparam int CNT_W = 5;
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(FRAME_LEN - 1);

    localparam logic [2:0] CMP_NONE = 3'b000;
    localparam logic [2:0] CMP_GT   = 3'b001;
    localparam logic [2:0] CMP_EQ   = 3'b010;
    localparam logic [2:0] CMP_LT   = 3'b100;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic [DATA_W-1:0] max_q, max_d;
    logic [DATA_W-1:0] min_q, min_d;
    logic [DATA_W-1:0] prev_q, prev_d;
    logic [3:0]        idx_q, idx_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [2:0]        cmp_q, cmp_d;
    logic              ready_w;
    logic              valid_w;
    logic              accept_w;

    // Handshake: a sample transfers on a rising edge where iValid && oReady;
    // the frame result transfers on a rising edge where oValid && iAck.
    assign accept_w = iValid && ready_w;

    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (accept_w) begin
                    state_d = (FRAME_LEN == 1) ? DONE : ACCUM;
                end
            end
            ACCUM: begin
                if (accept_w && (cnt_q == LAST_IDX)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (iAck) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        ready_w = (state_q != DONE);
        valid_w = (state_q == DONE);
    end

    always_comb begin
        max_d  = max_q;
        min_d  = min_q;
        prev_d = prev_q;
        idx_d  = idx_q;
        cnt_d  = cnt_q;
        cmp_d  = cmp_q;
        if (accept_w) begin
            prev_d = iData;
            cnt_d  = cnt_q + CNT_W'(1);
            if (state_q == IDLE) begin
                max_d = iData;
                min_d = iData;
                idx_d = 4'd0;
                cnt_d = CNT_W'(1);
                cmp_d = CMP_NONE;
            end else begin
                if (iData > prev_q) begin
                    cmp_d = CMP_GT;
                end else if (iData < prev_q) begin
                    cmp_d = CMP_LT;
                end else begin
                    cmp_d = CMP_EQ;
                end
                // Strict compares: ties keep the earlier index and value.
                if (iData > max_q) begin
                    max_d = iData;
                    idx_d = cnt_q[3:0];
                end
                if (iData < min_q) begin
                    min_d = iData;
                end
            end
        end else if ((state_q == DONE) && iAck) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            max_q  <= '0;
            min_q  <= '0;
            prev_q <= '0;
            idx_q  <= '0;
            cnt_q  <= '0;
            cmp_q  <= CMP_NONE;
        end else begin
            max_q  <= max_d;
            min_q  <= min_d;
            prev_q <= prev_d;
            idx_q  <= idx_d;
            cnt_q  <= cnt_d;
            cmp_q  <= cmp_d;
        end
    end

    assign oReady    = ready_w;
    assign oValid    = valid_w;
    assign oCmp      = cmp_q;
    assign oMax      = max_q;
    assign oMin      = min_q;
    assign oMaxIdx   = idx_q;
    assign oDbgState = state_q;

endmodule

// File: tb/tb_max_min_tracker.sv
// Bench for max_min_tracker: directed frames with literal expectations plus a
// randomized phase checked every cycle against a frame-level reference model.
module tb_max_min_tracker;

    logic       clk;
    logic       rst_n;
    logic       iValid, iAck;
    logic [7:0] iData;
    logic       oReady, oValid;
    logic [2:0] oCmp;
    logic [7:0] oMax, oMin;
    logic [3:0] oMaxIdx;
    logic [1:0] oDbgState;

    logic       v1, a1;
    logic [7:0] d1;
    logic       r1_o, val1_o;
    logic [2:0] cmp1_o;
    logic [7:0] max1_o, min1_o;
    logic [3:0] idx1_o;
    logic [1:0] st1_o;

    int checks = 0;
    int errors = 0;
    bit cmp_en = 0;

    max_min_tracker #(.DATA_W(8), .FRAME_LEN(4)) dut (
        .iClk(clk), .iRst_n(rst_n), .iValid(iValid), .iData(iData),
        .oReady(oReady), .oCmp(oCmp), .oValid(oValid), .oMax(oMax),
        .oMin(oMin), .oMaxIdx(oMaxIdx), .iAck(iAck), .oDbgState(oDbgState)
    );

    max_min_tracker #(.DATA_W(8), .FRAME_LEN(1)) dut1 (
        .iClk(clk), .iRst_n(rst_n), .iValid(v1), .iData(d1),
        .oReady(r1_o), .oCmp(cmp1_o), .oValid(val1_o), .oMax(max1_o),
        .oMin(min1_o), .oMaxIdx(idx1_o), .iAck(a1), .oDbgState(st1_o)
    );

    // clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h @%0t", name, act, exp, $time);
        end
    endtask

    // reference model: a frame is a list of samples; results are computed from it
    logic [7:0] frame_q[$];
    logic [7:0] exp_q[$];
    bit         m_done;
    logic [2:0] m_cmp;
    logic [7:0] m_max, m_min;
    logic [3:0] m_idx;
    int         m_frames;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_q.delete();
            m_done = 0;
            m_cmp  = 3'b000;
            m_max  = 0;
            m_min  = 0;
            m_idx  = 0;
        end else if (m_done) begin
            if (iAck) begin
                m_done = 0;
                m_frames++;
                frame_q.delete();
            end
        end else if (iValid) begin
            if (frame_q.size() == 0)       m_cmp = 3'b000;
            else if (iData > frame_q[$])   m_cmp = 3'b001;
            else if (iData < frame_q[$])   m_cmp = 3'b100;
            else                           m_cmp = 3'b010;
            frame_q.push_back(iData);
            if (frame_q.size() == 4) begin
                m_max = frame_q[0];
                m_min = frame_q[0];
                m_idx = 0;
                for (int i = 1; i < 4; i++) begin
                    if (frame_q[i] > m_max) begin
                        m_max = frame_q[i];
                        m_idx = 4'(i);
                    end
                    if (frame_q[i] < m_min) m_min = frame_q[i];
                end
                exp_q = frame_q;
                m_done = 1;
            end
        end
    end

    // per-cycle compare against the model
    always @(negedge clk) begin
        if (cmp_en && rst_n) begin
            check("m_ready", {31'd0, oReady}, {31'd0, !m_done});
            check("m_valid", {31'd0, oValid}, {31'd0, m_done});
            check("m_cmp", {29'd0, oCmp}, {29'd0, m_cmp});
            if (m_done) begin
                check("m_max", {24'd0, oMax}, {24'd0, m_max});
                check("m_min", {24'd0, oMin}, {24'd0, m_min});
                check("m_idx", {28'd0, oMaxIdx}, {28'd0, m_idx});
            end
        end
    end

    // driver tasks
    task automatic send(input logic [7:0] d);
        iValid = 1'b1;
        iData  = d;
        @(posedge clk);
        #1;
        iValid = 1'b0;
    endtask

    task automatic ack();
        iAck = 1'b1;
        @(posedge clk);
        #1;
        iAck = 1'b0;
        check("ack_valid_low", {31'd0, oValid}, 32'd0);
    endtask

    initial begin
        rst_n = 1'b0; iValid = 0; iAck = 0; iData = 0;
        v1 = 0; a1 = 0; d1 = 0;
        m_frames = 0;
        #2;
        check("rst_valid", {31'd0, oValid}, 32'd0);
        check("rst_ready", {31'd0, oReady}, 32'd1);
        check("rst_max", {24'd0, oMax}, 32'd0);
        check("rst_cmp", {29'd0, oCmp}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        cmp_en = 1;

        // rising/falling with a repeated max
        send(8'h12); check("t1_cmp0", {29'd0, oCmp}, 32'b000);
        send(8'h7F); check("t1_cmp1", {29'd0, oCmp}, 32'b001);
        send(8'h03); check("t1_cmp2", {29'd0, oCmp}, 32'b100);
        send(8'h7F); check("t1_cmp3", {29'd0, oCmp}, 32'b001);
        check("t1_valid", {31'd0, oValid}, 32'd1);
        check("t1_max", {24'd0, oMax}, 32'h7F);
        check("t1_min", {24'd0, oMin}, 32'h03);
        check("t1_idx", {28'd0, oMaxIdx}, 32'd1);
        check("model_max", {24'd0, m_max}, 32'h7F);
        check("model_idx", {28'd0, m_idx}, 32'd1);
        ack();

        // all equal
        send(8'h55); check("t2_cmp0", {29'd0, oCmp}, 32'b000);
        send(8'h55); check("t2_cmp1", {29'd0, oCmp}, 32'b010);
        send(8'h55); check("t2_cmp2", {29'd0, oCmp}, 32'b010);
        send(8'h55); check("t2_cmp3", {29'd0, oCmp}, 32'b010);
        check("t2_max", {24'd0, oMax}, 32'h55);
        check("t2_min", {24'd0, oMin}, 32'h55);
        check("t2_idx", {28'd0, oMaxIdx}, 32'd0);
        ack();

        // hold in DONE with a sample pending, then ack
        send(8'h10); send(8'h20); send(8'h30); send(8'h40);
        iValid = 1'b1; iData = 8'hAA;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            check("t3_hold_valid", {31'd0, oValid}, 32'd1);
            check("t3_hold_ready", {31'd0, oReady}, 32'd0);
            check("t3_hold_max", {24'd0, oMax}, 32'h40);
            check("t3_hold_idx", {28'd0, oMaxIdx}, 32'd3);
        end
        iAck = 1'b1;
        @(posedge clk); #1;
        iAck = 1'b0;
        check("t3_idle_valid", {31'd0, oValid}, 32'd0);
        check("t3_idle_ready", {31'd0, oReady}, 32'd1);
        @(posedge clk); #1;
        iValid = 1'b0;
        check("t3_new_max", {24'd0, oMax}, 32'hAA);
        check("t3_new_cmp", {29'd0, oCmp}, 32'b000);
        send(8'h01); send(8'hAA); send(8'h02);
        check("t3_f_max", {24'd0, oMax}, 32'hAA);
        check("t3_f_min", {24'd0, oMin}, 32'h01);
        check("t3_f_idx", {28'd0, oMaxIdx}, 32'd0);
        ack();

        // reset mid-frame
        send(8'h90); send(8'h91);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("t4_rst_valid", {31'd0, oValid}, 32'd0);
        check("t4_rst_ready", {31'd0, oReady}, 32'd1);
        check("t4_rst_max", {24'd0, oMax}, 32'd0);
        check("t4_rst_min", {24'd0, oMin}, 32'd0);
        check("t4_rst_idx", {28'd0, oMaxIdx}, 32'd0);
        check("t4_rst_cmp", {29'd0, oCmp}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        send(8'h01); send(8'h02); send(8'h03); send(8'h04);
        check("t4_valid", {31'd0, oValid}, 32'd1);
        check("t4_max", {24'd0, oMax}, 32'h04);
        check("t4_min", {24'd0, oMin}, 32'h01);
        check("t4_idx", {28'd0, oMaxIdx}, 32'd3);
        ack();

        // single-sample frames
        check("t5_ready_pre", {31'd0, r1_o}, 32'd1);
        v1 = 1'b1; d1 = 8'hFF;
        @(posedge clk); #1;
        v1 = 1'b0;
        check("t5_valid", {31'd0, val1_o}, 32'd1);
        check("t5_ready", {31'd0, r1_o}, 32'd0);
        check("t5_max", {24'd0, max1_o}, 32'hFF);
        check("t5_min", {24'd0, min1_o}, 32'hFF);
        check("t5_idx", {28'd0, idx1_o}, 32'd0);
        check("t5_cmp", {29'd0, cmp1_o}, 32'b000);
        a1 = 1'b1;
        @(posedge clk); #1;
        a1 = 1'b0;
        check("t5_ack_valid", {31'd0, val1_o}, 32'd0);

        // random gaps and stray acks, checked by the per-cycle compare
        begin
            int f0;
            f0 = m_frames;
            for (int c = 0; c < 300; c++) begin
                iValid = 1'($urandom_range(0, 1));
                iData  = 8'($urandom_range(0, 255));
                iAck   = ($urandom_range(0, 2) == 0);
                @(posedge clk); #1;
            end
            iValid = 0; iAck = 0;
            check("rand_frames_ge3", {31'd0, (m_frames - f0) >= 3}, 32'd1);
        end

        @(negedge clk);
        cmp_en = 0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/max_min_tracker.md
MAX_MIN_TRACKER -- requirements
Module: max_min_tracker

Interface
REQ-001 The module SHALL have parameter DATA_W, default 8, sample width in bits.
REQ-002 The module SHALL have parameter FRAME_LEN, default 4, samples per frame, legal range 1..16.
REQ-003 The module SHALL have port iClk, input, 1, the single clock; all state changes on its rising edge.
REQ-004 The module SHALL have port iRst_n, input, 1; reset is asynchronous and active-low.
REQ-005 The module SHALL have port iValid, input, 1, sample offered on iData.
REQ-006 The module SHALL have port iData, input, DATA_W, unsigned sample.
REQ-007 The module SHALL have port oReady, output, 1; a sample is accepted on a rising edge when iValid and oReady are both 1.
REQ-008 The module SHALL have port oCmp, output, 3, compare code of the latest accepted sample against the previous sample in the same frame.
REQ-009 The module SHALL have port oValid, output, 1, frame result available.
REQ-010 The module SHALL have port oMax, output, DATA_W, frame maximum.
REQ-011 The module SHALL have port oMin, output, DATA_W, frame minimum.
REQ-012 The module SHALL have port oMaxIdx, output, 4, in-frame index (0-based) of the first occurrence of the maximum.
REQ-013 The module SHALL have port iAck, input, 1, consumer has taken the frame result.

Function
REQ-014 The compare code SHALL be one-hot: 001 when new > previous, 100 when new < previous, 010 when equal, 000 when no previous sample exists.
REQ-015 The module SHALL implement the states IDLE, ACCUM and DONE.
REQ-016 oReady SHALL be 1 in IDLE and ACCUM and 0 in DONE, decoded from the state register only.
REQ-017 In IDLE, an accepted sample SHALL load max=min=sample, idx=0, cnt=1 and oCmp=000.
REQ-018 From IDLE, an accepted sample SHALL move the block to ACCUM, or to DONE if FRAME_LEN=1.
REQ-019 In ACCUM, each accepted sample at index cnt SHALL update oCmp against the previously accepted sample.
REQ-020 max and idx SHALL be replaced only when the sample is strictly greater than max; ties keep the earlier index.
REQ-021 min SHALL be replaced only when the sample is strictly less than min.
REQ-022 Each accepted sample SHALL increment cnt.
REQ-023 A sample accepted when cnt=FRAME_LEN-1 SHALL move the block to DONE on that edge, so oValid is 1 in the cycle after the last sample is accepted (latency 1).
REQ-024 Cycles in which iValid=0 SHALL leave all state unchanged; gaps between samples are unlimited.
REQ-025 In DONE, oValid SHALL be 1 and oMax, oMin and oMaxIdx SHALL stay stable until iAck=1 is sampled.
REQ-026 When iAck=1 is sampled in DONE, the block SHALL return to IDLE, with oValid=0 from the next cycle.
REQ-027 When iAck and iValid are both 1 in DONE, the sample SHALL NOT be accepted, because oReady=0.
REQ-028 iAck outside DONE SHALL be ignored.
REQ-029 oMax, oMin and oMaxIdx SHALL hold their last frame values in IDLE and ACCUM until they are overwritten; they are only qualified by oValid.
REQ-030 oCmp SHALL hold its value while no sample is accepted.

Reset
REQ-031 While iRst_n=0, the block SHALL be in IDLE with oValid=0, oMax=0, oMin=0, oMaxIdx=0, oCmp=000 and cnt=0, asynchronously.
REQ-032 oReady SHALL be 1 during and immediately after reset.
REQ-033 Reset asserted mid-frame or in DONE SHALL discard the partial or unacknowledged frame; the first sample after release starts a new frame.

Verification
REQ-034 The bench SHALL cover: FRAME_LEN=4, samples 0x12,0x7F,0x03,0x7F back-to-back -> oCmp sequence 000,001,100,001; then oValid=1, oMax=0x7F, oMin=0x03, oMaxIdx=1.
REQ-035 The bench SHALL cover: samples 0x55 x4 -> oCmp 000,010,010,010; oMax=oMin=0x55, oMaxIdx=0.
REQ-036 The bench SHALL cover: oValid held 5 cycles with iAck=0 while iValid=1, iData=0xAA -> outputs stable, oReady=0, nothing accepted; iAck=1 -> IDLE next cycle, and the next frame starts with 0xAA.
REQ-037 The bench SHALL cover: 2 samples accepted, then iRst_n pulsed low -> all outputs 0 and oReady=1; 4 new samples 0x01,0x02,0x03,0x04 -> oMax=0x04, oMaxIdx=3, oMin=0x01.
REQ-038 The bench SHALL cover: FRAME_LEN=1, sample 0xFF -> oValid=1 the next cycle, oMax=oMin=0xFF, oMaxIdx=0, oCmp=000.
REQ-039 The bench SHALL cover: iValid toggled with random gaps over 3 frames -> results match the reference model, and iAck outside DONE has no effect.
